// File: rtl/comparator_pkg.sv
// Shared definitions for the chunked branch comparator: funct3 codes, FSM states
// and the branch decision helper.
package comparator_pkg;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLT  = 3'b100;
  localparam logic [2:0] OP_BGE  = 3'b101;
  localparam logic [2:0] OP_BLTU = 3'b110;
  localparam logic [2:0] OP_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_is_illegal(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b011);
  endfunction

  function automatic logic branch_taken(input logic [2:0] op, input logic eq,
                                        input logic lu, input logic ls);
    logic t;
    case (op)
      OP_BEQ:  t = eq;
      OP_BNE:  t = !eq;
      OP_BLT:  t = ls;
      OP_BGE:  t = !ls;
      OP_BLTU: t = lu;
      OP_BGEU: t = !lu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/chunked_branch_comparator_chunk_compare.sv
// Combinational equality / unsigned less-than on one CHUNK-bit slice.
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] chunk_a_i,
  input  logic [CHUNK-1:0] chunk_b_i,
  output logic             chunk_eq,
  output logic             chunk_lt
);

  assign chunk_eq = (chunk_a_i == chunk_b_i);
  assign chunk_lt = (chunk_a_i <  chunk_b_i);

endmodule

// File: rtl/chunked_branch_comparator.sv
// Multi-cycle EQ/LTU/LTS comparator with RV32I branch decision, MSB chunk first.
// Define CHUNKED_BRANCH_COMPARATOR_EARLY_EXIT_EN to stop at the first differing chunk.
module chunked_branch_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lu,
  output logic             ls,
  output logic             taken,
  output logic             illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("chunked_branch_comparator: CHUNK must divide WIDTH");
  end

`ifdef CHUNKED_BRANCH_COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [2:0]        op_q;
  logic              found_q;
  logic              in_ready_q, out_valid_q;
  logic              eq_q, lu_q, ls_q, taken_q, illegal_q;

  logic [CHUNK-1:0]  chunk_a, chunk_b;
  logic              chunk_eq, chunk_lt;
  logic              eq_d, lu_d, ls_d;
  logic              capture, last_scan;

  assign chunk_a = CHUNK'(a_q >> (int'(idx_q) * CHUNK));
  assign chunk_b = CHUNK'(b_q >> (int'(idx_q) * CHUNK));

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .chunk_a_i (chunk_a),
    .chunk_b_i (chunk_b),
    .chunk_eq  (chunk_eq),
    .chunk_lt  (chunk_lt)
  );

  // When every chunk matched, chunk_lt is 0 and the sign bits agree, so one
  // formula covers both the differing-chunk and all-equal outcomes.
  always_comb begin
    eq_d      = chunk_eq;
    lu_d      = chunk_lt;
    ls_d      = chunk_lt ^ (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    capture   = !found_q && (!chunk_eq || (idx_q == '0));
    last_scan = EARLY_EXIT ? (!chunk_eq || (idx_q == '0)) : (idx_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= IDX_LAST;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      found_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      eq_q        <= 1'b0;
      lu_q        <= 1'b0;
      ls_q        <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= op;
            idx_q      <= IDX_LAST;
            found_q    <= 1'b0;
            in_ready_q <= 1'b0;
            eq_q       <= 1'b0;
            lu_q       <= 1'b0;
            ls_q       <= 1'b0;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          // Later chunks must not overwrite the first-difference result.
          if (capture) begin
            found_q   <= 1'b1;
            eq_q      <= eq_d;
            lu_q      <= lu_d;
            ls_q      <= ls_d;
            taken_q   <= branch_taken(op_q, eq_d, lu_d, ls_d);
            illegal_q <= op_is_illegal(op_q);
          end
          if (last_scan) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            idx_q       <= IDX_LAST;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign eq        = eq_q;
  assign lu        = lu_q;
  assign ls        = ls_q;
  assign taken     = taken_q;
  assign illegal   = illegal_q;

endmodule
